direction_queue: RTL and testbench

- Consumes the one-cycle press pulses from the button debouncer and turns them into a filtered, buffered stream of movement directions for the game logic.
- Each accepted press is queued in a small FIFO.
- On every game-step strobe, the oldest queued direction becomes the current heading.
- Illegal moves (same as the current heading, or a 180° reversal) are rejected on entry, so rapid key sequences between ticks are not lost or corrupted.

---
 rtl/direction_queue_pkg.sv | 19 +
 rtl/direction_queue_if.sv | 31 +++
 rtl/direction_queue_dir_fifo.sv | 64 ++++++
 rtl/direction_queue.sv | 98 +++++++++
 tb/tb_direction_queue.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/direction_queue_pkg.sv
// Shared game definitions: direction encoding and helpers used by the
// direction queue, the game logic and the renderer.
package direction_queue_pkg;

    localparam int DIR_W = 2;

    typedef logic [DIR_W-1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_RIGHT = 2'd1;
    localparam dir_t DIR_DOWN  = 2'd2;
    localparam dir_t DIR_LEFT  = 2'd3;

    // The encoding places each direction two steps from its reversal.
    function automatic dir_t opposite(input dir_t d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/direction_queue_if.sv
// Player-input / game-step bundle between the input front end and the
// direction queue.
interface direction_queue_if
    import direction_queue_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          clear;
    logic          up_pressed;
    logic          down_pressed;
    logic          left_pressed;
    logic          right_pressed;
    logic          tick;
    dir_t          dir;
    logic          step;
    logic [CW-1:0] count;
    logic          drop;

    modport master (
        output clear, up_pressed, down_pressed, left_pressed, right_pressed, tick,
        input  dir, step, count, drop
    );

    modport slave (
        input  clear, up_pressed, down_pressed, left_pressed, right_pressed, tick,
        output dir, step, count, drop
    );

endinterface

// File: rtl/direction_queue_dir_fifo.sv
// Small synchronous FIFO of directions with a combinational head read and
// a tail peek of the most recently pushed entry.
module dir_fifo
    import direction_queue_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  dir_t          wr_data,
    output dir_t          head,
    output dir_t          tail,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    dir_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];
    assign tail  = mem_q[wr_ptr_q - AW'(1)];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst && !clear && do_push)
            mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/direction_queue.sv
// Turns debounced key presses into a filtered queue of headings, releasing
// one heading per game-step tick.
module direction_queue
    import direction_queue_pkg::*;
#(
    parameter int   DEPTH    = 4,
    parameter dir_t INIT_DIR = DIR_RIGHT
) (
    input  logic             clk,
    input  logic             reset,
    direction_queue_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);

    dir_t          dir_q, dir_d;
    logic          step_q, step_d;
    logic          drop_q, drop_d;

    dir_t          sel;
    logic          any_press;
    dir_t          ref_dir;
    logic          accept;
    logic          pop;
    dir_t          fifo_head;
    dir_t          fifo_tail;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    // Fixed priority up > down > left > right; losers are simply ignored.
    always_comb begin
        sel       = DIR_UP;
        any_press = 1'b1;
        if (bus.up_pressed)         sel = DIR_UP;
        else if (bus.down_pressed)  sel = DIR_DOWN;
        else if (bus.left_pressed)  sel = DIR_LEFT;
        else if (bus.right_pressed) sel = DIR_RIGHT;
        else                        any_press = 1'b0;
    end

    // New presses are judged against the heading the snake will have once
    // everything already queued has been applied.
    always_comb begin
        ref_dir = fifo_empty ? dir_q : fifo_tail;
        accept  = any_press && !bus.clear &&
                  (sel != ref_dir) && (sel != opposite(ref_dir));
        pop     = bus.tick && !bus.clear;
    end

    always_comb begin
        dir_d  = dir_q;
        step_d = 1'b0;
        drop_d = 1'b0;
        if (bus.clear) begin
            dir_d = INIT_DIR;
        end else begin
            if (bus.tick && !fifo_empty)
                dir_d = fifo_head;
            step_d = bus.tick;
            drop_d = accept && fifo_full && !bus.tick;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q  <= INIT_DIR;
            step_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            dir_q  <= dir_d;
            step_q <= step_d;
            drop_q <= drop_d;
        end
    end

    dir_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .srst    (reset),
        .clear   (bus.clear),
        .push    (accept),
        .pop     (pop),
        .wr_data (sel),
        .head    (fifo_head),
        .tail    (fifo_tail),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.dir   = dir_q;
    assign bus.step  = step_q;
    assign bus.count = fifo_count;
    assign bus.drop  = drop_q;

endmodule

// File: tb/tb_direction_queue.sv
// Directed bench for direction_queue: hand-computed expectations for reset,
// filtering, queue ordering, overflow and clear behaviour.
module tb_direction_queue;
    import direction_queue_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    direction_queue_if #(.DEPTH(4)) bus ();

    direction_queue #(
        .DEPTH    (4),
        .INIT_DIR (DIR_RIGHT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.clear         = 1'b0;
        bus.up_pressed    = 1'b0;
        bus.down_pressed  = 1'b0;
        bus.left_pressed  = 1'b0;
        bus.right_pressed = 1'b0;
        bus.tick          = 1'b0;
    endtask

    // One press pulse (0=up,1=right,2=down,3=left), one cycle long.
    task automatic press(input int d);
        bus.up_pressed    = (d == 0);
        bus.right_pressed = (d == 1);
        bus.down_pressed  = (d == 2);
        bus.left_pressed  = (d == 3);
        cycle();
        idle_inputs();
    endtask

    task automatic tick_once();
        bus.tick = 1'b1;
        cycle();
        idle_inputs();
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        cycle();
        idle_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;

        check("rst_dir",   8'(bus.dir),   8'd1);
        check("rst_count", 8'(bus.count), 8'd0);
        check("rst_step",  8'(bus.step),  8'd0);
        check("rst_drop",  8'(bus.drop),  8'd0);

        // Ticks with nothing queued: heading holds, step still pulses.
        for (int i = 0; i < 3; i++) begin
            tick_once();
            check("idle_tick_step",  8'(bus.step),  8'd1);
            check("idle_tick_dir",   8'(bus.dir),   8'd1);
            check("idle_tick_count", 8'(bus.count), 8'd0);
            cycle();
            check("idle_step_low",   8'(bus.step),  8'd0);
        end

        // Reversal rejected, perpendicular accepted, applied on tick.
        press(3);
        check("rev_rejected", 8'(bus.count), 8'd0);
        check("rev_no_drop",  8'(bus.drop),  8'd0);
        press(1);
        check("same_rejected", 8'(bus.count), 8'd0);
        press(0);
        check("up_accepted", 8'(bus.count), 8'd1);
        check("up_dir_held", 8'(bus.dir),   8'd1);
        tick_once();
        check("up_applied_dir",   8'(bus.dir),   8'd0);
        check("up_applied_step",  8'(bus.step),  8'd1);
        check("up_applied_count", 8'(bus.count), 8'd0);

        // Sequence filtered against the queue tail, drained in order.
        do_clear();
        check("clear_dir", 8'(bus.dir), 8'd1);
        press(0);
        press(3);
        press(2);
        check("seq_count", 8'(bus.count), 8'd3);
        tick_once();
        check("seq_dir0", 8'(bus.dir), 8'd0);
        tick_once();
        check("seq_dir1", 8'(bus.dir), 8'd3);
        tick_once();
        check("seq_dir2",   8'(bus.dir),   8'd2);
        check("seq_empty",  8'(bus.count), 8'd0);

        // From DOWN: left, up, left, up fills the queue; one more overflows.
        press(3);
        press(0);
        press(3);
        press(0);
        check("fill_count",  8'(bus.count), 8'd4);
        check("fill_nodrop", 8'(bus.drop),  8'd0);
        press(3);
        check("ovf_drop",  8'(bus.drop),  8'd1);
        check("ovf_count", 8'(bus.count), 8'd4);
        cycle();
        check("ovf_drop_pulse", 8'(bus.drop), 8'd0);
        // Same press alongside a tick: the pop makes room.
        bus.left_pressed = 1'b1;
        bus.tick         = 1'b1;
        cycle();
        idle_inputs();
        check("full_pp_drop",  8'(bus.drop),  8'd0);
        check("full_pp_count", 8'(bus.count), 8'd4);
        check("full_pp_dir",   8'(bus.dir),   8'd3);
        check("full_pp_step",  8'(bus.step),  8'd1);
        cycle();
        check("full_pp_drop_late", 8'(bus.drop), 8'd0);

        // Simultaneous up + left: only up survives priority.
        do_clear();
        check("clear2_count", 8'(bus.count), 8'd0);
        bus.up_pressed   = 1'b1;
        bus.left_pressed = 1'b1;
        cycle();
        idle_inputs();
        check("prio_count", 8'(bus.count), 8'd1);
        tick_once();
        check("prio_dir", 8'(bus.dir), 8'd0);

        // Push while empty with a tick: queued, not applied this step.
        do_clear();
        bus.up_pressed = 1'b1;
        bus.tick       = 1'b1;
        cycle();
        idle_inputs();
        check("empty_pp_dir",   8'(bus.dir),   8'd1);
        check("empty_pp_count", 8'(bus.count), 8'd1);
        tick_once();
        check("empty_pp_next", 8'(bus.dir), 8'd0);

        // Clear with a concurrent tick wipes the queue and suppresses step.
        do_clear();
        press(0);
        press(3);
        check("pre_clear_count", 8'(bus.count), 8'd2);
        bus.clear = 1'b1;
        bus.tick  = 1'b1;
        cycle();
        idle_inputs();
        check("clr_tick_dir",   8'(bus.dir),   8'd1);
        check("clr_tick_count", 8'(bus.count), 8'd0);
        check("clr_tick_step",  8'(bus.step),  8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
